// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues 1-cycle-latency ROM reads and
// buffers {instr, pc} in a FIFO drained by decode over a valid/ready handshake.
module fetch_queue #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [PC_W-1:0]            out_pc_plus1,
  output logic [$clog2(DEPTH):0]     fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_inflight_pc;
  logic            r_inflight;
  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic   w_space;
  logic   w_issue;
  logic   w_push;
  logic   w_valid;
  logic   w_pop;
  entry_t w_head;

  // Counting the in-flight read as occupied guarantees its response a free slot.
  assign w_space = (r_count + CW'(r_inflight)) < CW'(DEPTH);
  assign w_issue = fetch_en & ~redirect_valid & ~reset & w_space;
  assign w_push  = r_inflight & ~redirect_valid & ~reset;
  assign w_valid = (r_count != '0) & ~redirect_valid & ~reset;
  assign w_pop   = w_valid & out_ready;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + PC_W'(1);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{instr: imem_rdata, pc: r_inflight_pc};
  end

  assign imem_req     = w_issue;
  assign imem_addr    = r_fetch_pc;
  assign out_valid    = w_valid;
  assign out_instr    = w_valid ? w_head.instr : '0;
  assign out_pc       = w_valid ? w_head.pc : '0;
  assign out_pc_plus1 = w_valid ? w_head.pc + PC_W'(1) : '0;
  assign fifo_count   = r_count;
endmodule
